// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and default frame geometry
// used by both the receive and transmit sides.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/EdgeSyncEn.sv
// Enabled two-stage synchronizer with edge detection. Registers advance only
// on cycles with en high; edges compare the synchronized level with the
// previous synchronized level, so fall/rise hold between enabled cycles.
module EdgeSyncEn #(
    parameter logic phase = 1'b1
) (
    input  logic clk,
    input  logic nReset,
    input  logic en,
    input  logic in,
    output logic out,
    output logic fall,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Shift the input through meta/sync stages and remember the last synced level.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            meta_q <= phase;
            sync_q <= phase;
            prev_q <= phase;
        end else if (en) begin
            meta_q <= in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign out  = sync_q;
    assign fall = prev_q & ~sync_q;
    assign rise = ~prev_q & sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-edge detection, mid-bit sampling of start,
// data (LSB first) and stop bits, valid/ready holding register and sticky
// framing-error / overrun flags.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 tick,
    input  logic                 en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frameErr,
    output logic                 overrun,
    input  logic                 clear,
    output logic                 busy
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);

    localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] FULL_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

    rxState_t             state_q;
    logic [TCW-1:0]       tick_cnt_q;
    logic [BCW-1:0]       bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;

    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_q;
    logic                 valid_d;
    logic                 frame_err_q;
    logic                 frame_err_d;
    logic                 overrun_q;
    logic                 overrun_d;

    logic step_s;
    logic line_s;
    logic fall_s;
    // The rising edge is deliberately ignored: only the mid-bit sample of the
    // start bit decides whether a frame is real.
    logic rise_unused_s;
    logic stop_sample_s;
    logic word_done_s;
    logic frame_bad_s;
    logic take_s;

    assign step_s = tick & en;

    EdgeSyncEn #(
        .phase (1'b1)
    ) u_sync (
        .clk    (clk),
        .nReset (nReset),
        .en     (step_s),
        .in     (rx),
        .out    (line_s),
        .fall   (fall_s),
        .rise   (rise_unused_s)
    );

    // Frame sequencer: bit timing counters, shift register and state.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            tick_cnt_q <= {TCW{1'b0}};
            bit_cnt_q  <= {BCW{1'b0}};
            shift_q    <= {DATA_BITS{1'b0}};
        end else if (!en) begin
            state_q    <= IDLE;
            tick_cnt_q <= {TCW{1'b0}};
            bit_cnt_q  <= {BCW{1'b0}};
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    if (fall_s) begin
                        state_q    <= START;
                        tick_cnt_q <= {TCW{1'b0}};
                    end
                end
                START: begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_q <= {TCW{1'b0}};
                        if (!line_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= {BCW{1'b0}};
                        end else begin
                            // Line went back high by mid start bit: a glitch.
                            state_q <= IDLE;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TCW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        shift_q    <= {line_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q  <= bit_cnt_q + BCW'(1);
                        tick_cnt_q <= {TCW{1'b0}};
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= STOP;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TCW'(1);
                    end
                end
                STOP: begin
                    // Return to IDLE mid stop bit so an early next start edge is caught.
                    if (tick_cnt_q == FULL_LAST) begin
                        state_q    <= IDLE;
                        tick_cnt_q <= {TCW{1'b0}};
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TCW'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tick_cnt_q <= {TCW{1'b0}};
                    bit_cnt_q  <= {BCW{1'b0}};
                end
            endcase
        end
    end

    assign stop_sample_s = step_s && (state_q == STOP) && (tick_cnt_q == FULL_LAST);
    assign word_done_s   = stop_sample_s & line_s;
    assign frame_bad_s   = stop_sample_s & ~line_s;
    assign take_s        = valid_q & ready;

    // Holding register, handshake and sticky flags; a flag set beats clear.
    always_comb begin
        data_d      = data_q;
        valid_d     = take_s ? 1'b0 : valid_q;
        frame_err_d = clear ? 1'b0 : frame_err_q;
        overrun_d   = clear ? 1'b0 : overrun_q;
        if (word_done_s) begin
            if (!valid_q || take_s) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (frame_bad_s) begin
            frame_err_d = 1'b1;
        end else begin
            data_d = data_q;
        end
    end

    // Register the output-side state every clk, independent of tick.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            data_q      <= {DATA_BITS{1'b0}};
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign frameErr = frame_err_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: default 8N1/16x instance plus a 5-bit/8x
// instance. Each tick is two clk cycles: the tick cycle and a plain cycle.
module tb_uart_rx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nReset, tick, en, ready, clear, rx_a, rx_b;
    logic [7:0] data_a;
    logic       valid_a, ferr_a, ovr_a, busy_a;
    logic [4:0] data_b;
    logic       valid_b, ferr_b, ovr_b, busy_b;

    uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16)) dut_a (
        .clk(clk), .nReset(nReset), .tick(tick), .en(en), .rx(rx_a),
        .data(data_a), .valid(valid_a), .ready(ready), .frameErr(ferr_a),
        .overrun(ovr_a), .clear(clear), .busy(busy_a)
    );

    uart_rx_ctrl #(.DATA_BITS(5), .OVERSAMPLE(8)) dut_b (
        .clk(clk), .nReset(nReset), .tick(tick), .en(en), .rx(rx_b),
        .data(data_b), .valid(valid_b), .ready(ready), .frameErr(ferr_b),
        .overrun(ovr_b), .clear(clear), .busy(busy_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit sel     = 1'b0;
    int v_off;
    int v_len;
    logic [8:0] v_data;

    function automatic logic cur_valid();
        return sel ? valid_b : valid_a;
    endfunction

    function automatic logic [8:0] cur_data();
        return sel ? {4'b0000, data_b} : {1'b0, data_a};
    endfunction

    task automatic clk_cycle();
        @(posedge clk);
        #1;
        if (cur_valid()) v_len++;
    endtask

    task automatic do_tick(input int o, input int ready_off);
        logic keep;
        keep = ready;
        if (o == ready_off) ready = 1'b1;
        tick = 1'b1;
        clk_cycle();
        if (cur_valid() && v_off < 0 && o >= 0) begin
            v_off  = o;
            v_data = cur_data();
        end
        ready = keep;
        tick  = 1'b0;
        clk_cycle();
    endtask

    task automatic idle_ticks(input int n);
        rx_a = 1'b1;
        rx_b = 1'b1;
        for (int i = 0; i < n; i++) do_tick(-1, -99);
    endtask

    // Offset 0 is the first tick that samples the start bit low.
    task automatic send_frame(input logic [8:0] val, input int nb, input int os,
                              input logic stop_bit, input int ready_off, input int max_ticks);
        int o;
        logic b;
        o = 0;
        v_off = -1;
        v_len = 0;
        for (int j = 0; j < nb + 2; j++) begin
            if (j == 0) b = 1'b0;
            else if (j == nb + 1) b = stop_bit;
            else b = val[j-1];
            for (int t = 0; t < os; t++) begin
                if (o >= max_ticks) return;
                if (sel) rx_b = b; else rx_a = b;
                do_tick(o, ready_off);
                o++;
            end
        end
        if (sel) rx_b = 1'b1; else rx_a = 1'b1;
    endtask

    task automatic test_reset();
        nReset = 1'b0; tick = 1'b0; en = 1'b1; ready = 1'b0; clear = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1;
        repeat (3) clk_cycle();
        n_tests++;
        if ({data_a, valid_a, ferr_a, ovr_a, busy_a} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected 000", {data_a, valid_a, ferr_a, ovr_a, busy_a});
        end
        n_tests++;
        if ({data_b, valid_b, ferr_b, ovr_b, busy_b} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected 000", {data_b, valid_b, ferr_b, ovr_b, busy_b});
        end
        nReset = 1'b1;
        clk_cycle();
        idle_ticks(8);
        n_tests++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b expected 0", busy_a);
        end
    endtask

    task automatic test_frame_receive();
        sel = 1'b0;
        ready = 1'b1;
        send_frame(9'h0A5, 8, 16, 1'b1, -99, 1000);
        ready = 1'b0;
        n_tests++;
        if (v_off !== 154) begin
            n_fail++;
            $display("FAIL frame_valid_tick: got %0d expected 154", v_off);
        end
        n_tests++;
        if (v_data !== 9'h0A5) begin
            n_fail++;
            $display("FAIL frame_data: got %h expected 0a5", v_data);
        end
        n_tests++;
        if (v_len !== 1) begin
            n_fail++;
            $display("FAIL frame_valid_len: got %0d expected 1", v_len);
        end
        n_tests++;
        if ({valid_a, ferr_a, ovr_a, busy_a} !== 4'b0000) begin
            n_fail++;
            $display("FAIL frame_end_status: got %b expected 0000", {valid_a, ferr_a, ovr_a, busy_a});
        end
    endtask

    task automatic test_start_glitch();
        logic [19:0] busy_hist;
        idle_ticks(4);
        v_off = -1;
        rx_a = 1'b0;
        for (int o = 0; o < 20; o++) begin
            if (o == 4) rx_a = 1'b1;
            do_tick(o, -99);
            busy_hist[o] = busy_a;
        end
        n_tests++;
        if ({busy_hist[1], busy_hist[2], busy_hist[9], busy_hist[10], busy_hist[19]} !== 5'b01100) begin
            n_fail++;
            $display("FAIL glitch_busy: got %b expected 01100 (ticks 1,2,9,10,19)",
                     {busy_hist[1], busy_hist[2], busy_hist[9], busy_hist[10], busy_hist[19]});
        end
        n_tests++;
        if ({valid_a, ferr_a, ovr_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL glitch_flags: got %b expected 000", {valid_a, ferr_a, ovr_a});
        end
    endtask

    task automatic test_framing_error();
        ready = 1'b1;
        send_frame(9'h03C, 8, 16, 1'b0, -99, 1000);
        ready = 1'b0;
        idle_ticks(4);
        n_tests++;
        if ({ferr_a, valid_a, ovr_a} !== 3'b100) begin
            n_fail++;
            $display("FAIL ferr_set: got %b expected 100", {ferr_a, valid_a, ovr_a});
        end
        n_tests++;
        if (data_a !== 8'hA5 || v_off !== -1) begin
            n_fail++;
            $display("FAIL ferr_data_kept: got %h/%0d expected a5/-1", data_a, v_off);
        end
        clear = 1'b1;
        clk_cycle();
        clear = 1'b0;
        n_tests++;
        if (ferr_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_clear: got %b expected 0", ferr_a);
        end
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        send_frame(9'h011, 8, 16, 1'b1, -99, 1000);
        send_frame(9'h022, 8, 16, 1'b1, -99, 1000);
        n_tests++;
        if ({data_a, valid_a, ovr_a, ferr_a} !== {8'h11, 3'b110}) begin
            n_fail++;
            $display("FAIL overrun_hold: got %h expected %h", {data_a, valid_a, ovr_a, ferr_a}, {8'h11, 3'b110});
        end
        ready = 1'b1;
        clk_cycle();
        ready = 1'b0;
        n_tests++;
        if (valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_consume: got %b expected 0", valid_a);
        end
        clear = 1'b1;
        clk_cycle();
        clear = 1'b0;
        n_tests++;
        if (ovr_a !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b expected 0", ovr_a);
        end
        send_frame(9'h011, 8, 16, 1'b1, -99, 1000);
        send_frame(9'h022, 8, 16, 1'b1, 154, 1000);
        n_tests++;
        if ({data_a, valid_a, ovr_a} !== {8'h22, 2'b10}) begin
            n_fail++;
            $display("FAIL overrun_same_cycle: got %h expected %h", {data_a, valid_a, ovr_a}, {8'h22, 2'b10});
        end
        ready = 1'b1;
        clk_cycle();
        ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        ready = 1'b0;
        send_frame(9'h0F0, 8, 16, 1'b1, -99, 60);
        n_tests++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy: got %b expected 1", busy_a);
        end
        nReset = 1'b0;
        rx_a = 1'b1;
        #2;
        n_tests++;
        if ({data_a, valid_a, ferr_a, ovr_a, busy_a} !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_abort: got %h expected 000", {data_a, valid_a, ferr_a, ovr_a, busy_a});
        end
        clk_cycle();
        nReset = 1'b1;
        idle_ticks(40);
        send_frame(9'h05A, 8, 16, 1'b1, -99, 1000);
        n_tests++;
        if (v_off !== 154 || data_a !== 8'h5A || valid_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_next_frame: got %0d/%h/%b expected 154/5a/1", v_off, data_a, valid_a);
        end
    endtask

    task automatic test_enable_abort();
        ready = 1'b0;
        send_frame(9'h0F0, 8, 16, 1'b1, -99, 60);
        en = 1'b0;
        clk_cycle();
        n_tests++;
        if ({busy_a, valid_a, data_a} !== {2'b01, 8'h5A}) begin
            n_fail++;
            $display("FAIL en_abort: got %h expected %h", {busy_a, valid_a, data_a}, {2'b01, 8'h5A});
        end
        rx_a = 1'b1;
        for (int i = 0; i < 5; i++) do_tick(-1, -99);
        ready = 1'b1;
        clk_cycle();
        ready = 1'b0;
        n_tests++;
        if ({valid_a, busy_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL en_low_handshake: got %b expected 00", {valid_a, busy_a});
        end
        en = 1'b1;
        idle_ticks(40);
        ready = 1'b1;
        send_frame(9'h05A, 8, 16, 1'b1, -99, 1000);
        ready = 1'b0;
        n_tests++;
        if (v_off !== 154 || v_data !== 9'h05A) begin
            n_fail++;
            $display("FAIL en_next_frame: got %0d/%h expected 154/05a", v_off, v_data);
        end
    endtask

    task automatic test_param_sweep();
        sel = 1'b1;
        ready = 1'b1;
        send_frame(9'h015, 5, 8, 1'b1, -99, 1000);
        ready = 1'b0;
        n_tests++;
        if (v_off !== 54) begin
            n_fail++;
            $display("FAIL sweep_valid_tick: got %0d expected 54", v_off);
        end
        n_tests++;
        if (v_data !== 9'h015 || v_len !== 1) begin
            n_fail++;
            $display("FAIL sweep_data: got %h/%0d expected 015/1", v_data, v_len);
        end
        n_tests++;
        if ({valid_b, ferr_b, ovr_b, busy_b} !== 4'b0000) begin
            n_fail++;
            $display("FAIL sweep_end_status: got %b expected 0000", {valid_b, ferr_b, ovr_b, busy_b});
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_receive();
        test_start_glitch();
        test_framing_error();
        test_back_to_back();
        test_reset_abort();
        test_enable_abort();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
